// File: rtl/wb_queue.sv
// Writeback queue: accepts up to two results per cycle (load older than ALU),
// retires one per cycle into the register file C port, and forwards pending values.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_dst,
    input  logic [DW-1:0] ld_data,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_dst,
    input  logic [DW-1:0] alu_data,
    output logic          ready,
    output logic          overflow,
    output logic          empty,
    output logic [DW-1:0] rf_din,
    output logic [AW-1:0] rf_csel,
    output logic          rf_c_we,
    input  logic [AW-1:0] asel,
    input  logic [AW-1:0] bsel,
    output logic          a_hit,
    output logic [DW-1:0] a_data,
    output logic          b_hit,
    output logic [DW-1:0] b_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] dst_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic          ld_live, alu_live, pop, fits, accept;
    logic [1:0]    n_push;
    logic [CW:0]   space_need;
    logic [PW-1:0] alu_idx;

    assign ld_live  = ld_valid  && (ld_dst  != '0);
    assign alu_live = alu_valid && (alu_dst != '0);
    assign n_push   = {1'b0, ld_live} + {1'b0, alu_live};
    assign pop      = (count_reg != '0);

    // Space is judged after this edge's pop; a pair that does not fit is dropped whole.
    assign space_need = {1'b0, count_reg} - {{CW{1'b0}}, pop} + {{(CW-1){1'b0}}, n_push};
    assign fits       = (space_need <= (CW+1)'(DEPTH));
    assign accept     = (n_push != 2'd0) && fits;
    assign alu_idx    = tail_reg + PW'(ld_live);

    always_comb begin
        head_next     = head_reg + PW'(pop);
        tail_next     = tail_reg;
        count_next    = count_reg - CW'(pop);
        overflow_next = overflow_reg;
        if (accept) begin
            tail_next  = tail_reg + PW'(n_push);
            count_next = count_reg - CW'(pop) + CW'(n_push);
        end else if (n_push != 2'd0) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Entry storage and an age-ordered view (age 0 = head) for the bypass search.
    logic [AW-1:0] age_dst  [DEPTH];
    logic [DW-1:0] age_data [DEPTH];
    logic          age_occ  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (accept && ld_live && (tail_reg == PW'(gi))) begin
                    dst_mem[gi]  <= ld_dst;
                    data_mem[gi] <= ld_data;
                end else if (accept && alu_live && (alu_idx == PW'(gi))) begin
                    dst_mem[gi]  <= alu_dst;
                    data_mem[gi] <= alu_data;
                end
            end

            assign age_dst[gi]  = dst_mem[head_reg + PW'(gi)];
            assign age_data[gi] = data_mem[head_reg + PW'(gi)];
            assign age_occ[gi]  = (CW'(gi) < count_reg);
        end
    endgenerate

    // Scan oldest to youngest so the last match (youngest) is what remains.
    always_comb begin
        a_hit  = 1'b0;
        a_data = '0;
        b_hit  = 1'b0;
        b_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_occ[i] && (asel != '0) && (age_dst[i] == asel)) begin
                a_hit  = 1'b1;
                a_data = age_data[i];
            end
            if (age_occ[i] && (bsel != '0) && (age_dst[i] == bsel)) begin
                b_hit  = 1'b1;
                b_data = age_data[i];
            end
        end
    end

    assign rf_c_we  = pop;
    assign rf_csel  = pop ? dst_mem[head_reg]  : '0;
    assign rf_din   = pop ? data_mem[head_reg] : '0;
    assign empty    = !pop;
    assign ready    = (count_reg <= CW'(DEPTH - 2));
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, hand-written corner
// sequences, and random traffic against a queue-based reference model.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0, alu_valid = 1'b0;
    logic [AW-1:0] ld_dst = '0, alu_dst = '0, asel = '0, bsel = '0;
    logic [DW-1:0] ld_data = '0, alu_data = '0;
    logic          ready, overflow, empty, rf_c_we, a_hit, b_hit;
    logic [DW-1:0] rf_din, a_data, b_data;
    logic [AW-1:0] rf_csel;

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
        .ready(ready), .overflow(overflow), .empty(empty),
        .rf_din(rf_din), .rf_csel(rf_csel), .rf_c_we(rf_c_we),
        .asel(asel), .bsel(bsel),
        .a_hit(a_hit), .a_data(a_data), .b_hit(b_hit), .b_data(b_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain FIFO of pending writes plus the sticky drop flag.
    typedef struct {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } ent_t;
    ent_t mq[$];
    logic m_ovf = 1'b0;

    typedef struct {
        logic lv; logic [3:0] ld; logic [7:0] lda;
        logic av; logic [3:0] ad; logic [7:0] ada;
        logic [3:0] as; logic [3:0] bs;
        logic e_we; logic [3:0] e_csel; logic [7:0] e_din;
        logic e_ah; logic [7:0] e_ad; logic e_bh; logic [7:0] e_bd;
        logic e_empty; logic e_ready; logic e_ovf;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic lookup(input logic [AW-1:0] sel, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (sel != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].dst == sel) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        logic ah, bh;
        logic [DW-1:0] ad, bd;
        bit has = (mq.size() > 0);
        lookup(asel, ah, ad);
        lookup(bsel, bh, bd);
        chk("m_we",    rf_c_we, has);
        chk("m_csel",  rf_csel, has ? mq[0].dst  : 4'd0);
        chk("m_din",   rf_din,  has ? mq[0].data : 8'd0);
        chk("m_empty", empty,   !has);
        chk("m_ready", ready,   mq.size() <= DEPTH - 2);
        chk("m_ovf",   overflow, m_ovf);
        chk("m_ahit",  a_hit, ah);
        chk("m_adata", a_data, ad);
        chk("m_bhit",  b_hit, bh);
        chk("m_bdata", b_data, bd);
        $display("cyc q=%0d we=%0b csel=%0d din=%0h ovf=%0b", mq.size(), rf_c_we, rf_csel, rf_din, overflow);
    endtask

    task automatic drive(input logic lv, input logic [3:0] ld, input logic [7:0] lda,
                         input logic av, input logic [3:0] ad, input logic [7:0] ada,
                         input logic [3:0] as, input logic [3:0] bs);
        @(negedge clk);
        ld_valid = lv; ld_dst = ld; ld_data = lda;
        alu_valid = av; alu_dst = ad; alu_data = ada;
        asel = as; bsel = bs;
        #1;
    endtask

    task automatic commit();
        bit pl, pa;
        int n, p;
        @(posedge clk);
        pl = ld_valid && (ld_dst != 0);
        pa = alu_valid && (alu_dst != 0);
        n  = int'(pl) + int'(pa);
        p  = (mq.size() > 0) ? 1 : 0;
        if (p == 1) void'(mq.pop_front());
        if (n > 0) begin
            if (mq.size() + n <= DEPTH) begin
                if (pl) mq.push_back('{ld_dst, ld_data});
                if (pa) mq.push_back('{alu_dst, alu_data});
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic lv, input logic [3:0] ld, input logic [7:0] lda,
                       input logic av, input logic [3:0] ad, input logic [7:0] ada,
                       input logic [3:0] as, input logic [3:0] bs);
        drive(lv, ld, lda, av, ad, ada, as, bs);
        check_model();
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        chk("rst_we", rf_c_we, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0,4'd0,8'h00, 1'b1,4'd3,8'h5A, 4'd0,4'd0, 1'b0,4'd0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b1,1'b0};
        tbl[1] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,8'h00, 4'd3,4'd3, 1'b1,4'd3,8'h5A, 1'b1,8'h5A, 1'b1,8'h5A, 1'b0,1'b1,1'b0};
        tbl[2] = '{1'b1,4'd2,8'h11, 1'b1,4'd2,8'h22, 4'd2,4'd3, 1'b0,4'd0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b1,1'b0};
        tbl[3] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,8'h00, 4'd2,4'd3, 1'b1,4'd2,8'h11, 1'b1,8'h22, 1'b0,8'h00, 1'b0,1'b1,1'b0};
        tbl[4] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,8'h00, 4'd2,4'd2, 1'b1,4'd2,8'h22, 1'b1,8'h22, 1'b1,8'h22, 1'b0,1'b1,1'b0};
        tbl[5] = '{1'b0,4'd0,8'h00, 1'b1,4'd0,8'hFF, 4'd0,4'd2, 1'b0,4'd0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b1,1'b0};
        tbl[6] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,8'h00, 4'd0,4'd0, 1'b0,4'd0,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b1,1'b0};

        do_reset();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].lv, tbl[i].ld, tbl[i].lda, tbl[i].av, tbl[i].ad, tbl[i].ada, tbl[i].as, tbl[i].bs);
            chk("t_we",    rf_c_we, tbl[i].e_we);
            chk("t_csel",  rf_csel, tbl[i].e_csel);
            chk("t_din",   rf_din,  tbl[i].e_din);
            chk("t_ahit",  a_hit,   tbl[i].e_ah);
            chk("t_adata", a_data,  tbl[i].e_ad);
            chk("t_bhit",  b_hit,   tbl[i].e_bh);
            chk("t_bdata", b_data,  tbl[i].e_bd);
            chk("t_empty", empty,   tbl[i].e_empty);
            chk("t_ready", ready,   tbl[i].e_ready);
            chk("t_ovf",   overflow, tbl[i].e_ovf);
            $display("vec %0d we=%0b csel=%0d din=%0h ahit=%0b adata=%0h", i, rf_c_we, rf_csel, rf_din, a_hit, a_data);
            commit();
        end

        // Dual pushes every cycle ignoring ready
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 4'((2*k) % 15 + 1), 8'(8'h40 + 2*k), 1'b1, 4'((2*k+1) % 15 + 1), 8'(8'h41 + 2*k), 4'd1, 4'd2);
            check_model();
            if (mq.size() == 3) chk("flood_ready_at3", ready, 1'b0);
            commit();
        end
        chk("flood_ovf", overflow, 1'b1);
        for (int k = 0; k < 6; k++) cyc(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 4'd1, 4'd2);
        chk("flood_ovf_sticky", overflow, 1'b1);
        chk("flood_drained", empty, 1'b1);

        // Single pushes across pointer wrap
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 8'(8'hA0 + k), 4'd7, 4'd0);
            check_model();
            if (k > 0) begin
                chk("wrap_din", rf_din, 8'(8'hA0 + k - 1));
                chk("wrap_ready", ready, 1'b1);
            end
            commit();
        end
        cyc(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 4'd7, 4'd0);

        // Mid-cycle reset with three entries pending
        cyc(1'b1, 4'd2, 8'h31, 1'b1, 4'd3, 8'h32, 4'd0, 4'd0);
        cyc(1'b1, 4'd4, 8'h33, 1'b1, 4'd5, 8'h34, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 4'd5, 4'd3);
        check_model();
        chk("pre_rst_ahit", a_hit, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk("mid_rst_we", rf_c_we, 1'b0);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_ahit", a_hit, 1'b0);
        chk("mid_rst_bhit", b_hit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 4'd5, 4'd3);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 8'($urandom),
                1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 8'($urandom),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
